// File: rtl/ahb_ram_slave.sv
// AHB-Lite data-RAM slave for the 0xB0xxxxxx window.
// Decodes the address phase, inserts WAIT_STATES wait cycles before each OKAY
// completion, writes byte/half/word lanes and returns full-word read data.
// Misaligned or oversized transfers get the two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  // Counter reload; only used when WAIT_STATES > 0, so the zero case is a don't-care.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q,  size_d;
  logic [2:0]             cnt_q,   cnt_d;

  logic                   accept;
  logic                   req_err;
  logic [3:0]             be;
  logic                   mem_wr;
  logic [ADDR_WIDTH-3:0]  word_idx;
  logic [31:0]            rd_word;

  // Protection bits, BUSY/SEQ distinction and high address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, hprot, htrans[0], haddr[31:ADDR_WIDTH]};

  // A transfer is taken when selected, NONSEQ/SEQ, and the bus is ready.
  assign accept = hsel && htrans[1] && hready_in;

  // Misaligned halfword/word, or anything wider than a word, is rejected.
  always_comb begin
    req_err = 1'b0;
    if (hsize > 3'b010)
      req_err = 1'b1;
    else if (hsize == 3'b001 && haddr[0])
      req_err = 1'b1;
    else if (hsize == 3'b010 && haddr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  // Next-state, registered address phase and bus response outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    hready_out = 1'b1;
    hresp      = 1'b0;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        // These states complete (or have no) a transfer this cycle, so a new
        // address phase can be pipelined in at the same edge.
        if (state_q == S_ERR2)
          hresp = 1'b1;
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = haddr[ADDR_WIDTH-1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (req_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        hready_out = 1'b0;
        if (cnt_q == 3'd0)
          state_d = S_DATA;
        else
          cnt_d = cnt_q - 3'd1;
      end
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
        state_d    = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and address-phase registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  // Little-endian lane enables from the registered address and size.
  always_comb begin
    case (size_q[1:0])
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign mem_wr   = (state_q == S_DATA) && write_q;

  // One byte-wide array per lane; hwdata lanes are stored without shifting.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Commit the lane at the closing edge of a write data cycle; a reset
      // arriving at that edge discards the write.
      always_ff @(posedge clk) begin
        if (!reset && mem_wr && be[gi])
          lane_mem[word_idx] <= hwdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Read data is driven only during a read completion cycle.
  always_comb begin
    hrdata = 32'h0;
    if (state_q == S_DATA && !write_q)
      hrdata = rd_word;
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: one instance with two wait states and one
// with zero wait states, sharing clock and reset.
module tb_ahb_ram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Bus for the WAIT_STATES=2 instance
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [3:0]  hprot = 4'b0011;
  logic [31:0] hwdata = '0;
  logic        hready_out, hresp;
  logic [31:0] hrdata;

  // Bus for the WAIT_STATES=0 instance
  logic        b_hsel = 1'b0;
  logic [31:0] b_haddr = '0;
  logic [1:0]  b_htrans = 2'b00;
  logic        b_hwrite = 1'b0;
  logic [2:0]  b_hsize = 3'b010;
  logic [31:0] b_hwdata = '0;
  logic        b_hready_out, b_hresp;
  logic [31:0] b_hrdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready_in(hready_out), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata)
  );

  ahb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .hsel(b_hsel), .haddr(b_haddr), .htrans(b_htrans),
    .hwrite(b_hwrite), .hsize(b_hsize), .hprot(hprot), .hwdata(b_hwdata),
    .hready_in(b_hready_out), .hready_out(b_hready_out), .hresp(b_hresp), .hrdata(b_hrdata)
  );

  // Single non-pipelined transfer on the WAIT_STATES=2 bus. Entered and left
  // 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic resp, output logic first_resp, output int waits,
                      output logic wait_rdata_zero);
    bit done;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    waits = 0; wait_rdata_zero = 1'b1; first_resp = 1'b0; done = 0;
    rdata = '0; resp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) first_resp = hresp;
      if (hready_out) begin
        done = 1;
        break;
      end
      waits++;
      if (hrdata !== 32'h0) wait_rdata_zero = 1'b0;
    end
    rdata = hrdata;
    resp  = hresp;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: hready_out never rose, got waits=%0d required completion", waits);
    end
    $display("xfer wr=%0d addr=%08h size=%0d wdata=%08h -> rdata=%08h resp=%0d waits=%0d",
             wr, addr, size, wdata, rdata, resp, waits);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b required 1", hready_out); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b required 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %08h required 00000000", hrdata); end
    checks++; if (b_hready_out !== 1'b1) begin errors++; $display("FAIL reset_hready_ws0: got %b required 1", b_hready_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    // IDLE with hsel, then NONSEQ without hsel: both must see zero-wait OKAY.
    hsel = 1'b1; htrans = 2'b00; haddr = 32'hB000_0010; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b10;
    @(negedge clk);
    checks++; if (hready_out !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL idle_okay: got hready=%b hresp=%b required 1/0", hready_out, hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL idle_hrdata: got %08h required 00000000", hrdata); end
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    checks++; if (hready_out !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL unsel_okay: got hready=%b hresp=%b required 1/0", hready_out, hresp); end
    $display("xfer idle/unselected transfers observed hready=%b hresp=%b", hready_out, hresp);
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic rs, fr, wz; int w;
    xfer(1'b1, 32'hB000_0010, 3'b010, 32'hDEAD_BEEF, rd, rs, fr, w, wz);
    checks++; if (w != 2) begin errors++; $display("FAIL sw_waits: got %0d required 2", w); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL sw_resp: got %b required 0", rs); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_hrdata: got %08h required 00000000", rd); end
    xfer(1'b0, 32'hB000_0010, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %08h required deadbeef", rd); end
    checks++; if (w != 2 || rs !== 1'b0) begin errors++; $display("FAIL lw_timing: got waits=%0d resp=%b required 2/0", w, rs); end
    checks++; if (wz !== 1'b1) begin errors++; $display("FAIL lw_wait_hrdata: got nonzero during wait required 00000000"); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic rs, fr, wz; int w;
    xfer(1'b1, 32'hB000_0011, 3'b000, 32'h0000_AA00, rd, rs, fr, w, wz);
    xfer(1'b0, 32'hB000_0010, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL sb_merge: got %08h required deadaaef", rd); end
    xfer(1'b1, 32'hB000_0012, 3'b001, 32'h1234_0000, rd, rs, fr, w, wz);
    xfer(1'b0, 32'hB000_0010, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'h1234_AAEF) begin errors++; $display("FAIL sh_merge: got %08h required 1234aaef", rd); end
    // Upper address bits ignored: 0xB0001010 aliases 0xB0000010.
    xfer(1'b0, 32'hB000_1010, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'h1234_AAEF) begin errors++; $display("FAIL alias: got %08h required 1234aaef", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic rs, fr, wz; int w;
    logic [31:0] addrs [3];
    logic [2:0]  sizes [3];
    logic        wrs   [3];
    addrs[0] = 32'hB000_0013; sizes[0] = 3'b001; wrs[0] = 1'b1;
    addrs[1] = 32'hB000_0012; sizes[1] = 3'b010; wrs[1] = 1'b0;
    addrs[2] = 32'hB000_0010; sizes[2] = 3'b011; wrs[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      xfer(wrs[k], addrs[k], sizes[k], 32'hFFFF_FFFF, rd, rs, fr, w, wz);
      checks++; if (w != 1) begin errors++; $display("FAIL err%0d_len: got %0d low cycles required 1", k, w); end
      checks++; if (fr !== 1'b1) begin errors++; $display("FAIL err%0d_resp1: got %b required 1", k, fr); end
      checks++; if (rs !== 1'b1) begin errors++; $display("FAIL err%0d_resp2: got %b required 1", k, rs); end
    end
    xfer(1'b0, 32'hB000_0010, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'h1234_AAEF || rs !== 1'b0) begin errors++; $display("FAIL err_nowrite: got %08h resp=%b required 1234aaef/0", rd, rs); end
  endtask

  task automatic test_back_to_back();
    // Zero-wait instance: write address, then read address pipelined during the write data phase.
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'hB000_0020; b_hwrite = 1'b1; b_hsize = 3'b010;
    @(posedge clk); #1;
    b_hwdata = 32'hCAFE_F00D; b_hwrite = 1'b0; b_haddr = 32'hB000_0020;
    @(negedge clk);
    checks++; if (b_hready_out !== 1'b1 || b_hresp !== 1'b0) begin errors++; $display("FAIL b2b_wr_ready: got hready=%b hresp=%b required 1/0", b_hready_out, b_hresp); end
    checks++; if (b_hrdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_hrdata: got %08h required 00000000", b_hrdata); end
    $display("xfer ws0 wr addr=b0000020 wdata=cafef00d");
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwdata = 32'h0;
    @(negedge clk);
    checks++; if (b_hready_out !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b required 1", b_hready_out); end
    checks++; if (b_hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rd_data: got %08h required cafef00d", b_hrdata); end
    $display("xfer ws0 rd addr=b0000020 rdata=%08h", b_hrdata);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b_hrdata !== 32'h0) begin errors++; $display("FAIL b2b_idle_hrdata: got %08h required 00000000", b_hrdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic rs, fr, wz; int w;
    xfer(1'b1, 32'hB000_0020, 3'b010, 32'hCAFE_F00D, rd, rs, fr, w, wz);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hB000_0020; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got %b required 0", hready_out); end
    reset = 1'b1;
    #1;
    checks++; if (hready_out !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL abort_async: got hready=%b hresp=%b required 1/0", hready_out, hresp); end
    $display("xfer sw addr=b0000020 wdata=11111111 aborted by reset");
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'hB000_0020, 3'b010, 32'h0, rd, rs, fr, w, wz);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL abort_discard: got %08h required cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_word();
    test_subword();
    test_error();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
AHB-Lite data-RAM slave that sits directly downstream of the core's AHB master glue logic and serves its load/store transfers in the 0xB0xxxxxx window. It decodes the address phase and inserts a programmable number of wait states. It performs byte, halfword and word writes and returns full-word read data; the core applies sign/zero extension. Misaligned or oversized transfers get the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 12, byte-address bits used to index the RAM; depth = 2^(ADDR_WIDTH-2) words
WAIT_STATES, 2, wait cycles (hready_out=0) inserted before every OKAY completion; legal range 0..7

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
hsel  in  1  slave select from the address decoder (high for 0xB0xxxxxx)
haddr  in  32  transfer address; only [ADDR_WIDTH-1:0] is used
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 = write
hsize  in  3  000 byte, 001 half, 010 word
hprot  in  4  protection; accepted, not checked
hwdata  in  32  write data, valid during the data phase
hready_in  in  1  bus-level HREADY (previous transfer complete)
hready_out  out  1  slave ready / transfer completion
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  32  read data

Behaviour:
- Reset values: hready_out=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately. A pending write is discarded and the RAM is not modified.
- Address phase is accepted at a rising edge when hsel && htrans[1] && hready_in. On acceptance, register haddr[ADDR_WIDTH-1:0], hwrite and hsize.
- Error check at acceptance: hsize>010, or (hsize=001 and addr[0]=1), or (hsize=010 and addr[1:0]!=00) -> go to ERR1.
- FSM states:
  - IDLE: hready_out=1, hresp=0. A valid OKAY transfer goes to WAIT when WAIT_STATES>0, else to DATA. An error transfer goes to ERR1.
  - WAIT: hready_out=0, hresp=0. The counter loads WAIT_STATES-1 and decrements; at 0 go to DATA.
  - DATA (completion cycle): hready_out=1, hresp=0.
    - Write: hwdata is committed at the closing edge under the byte enables.
    - Read: hrdata = mem[addr_q[ADDR_WIDTH-1:2]], read combinationally.
    - Next state: a new transfer accepted at the same edge is pipelined into WAIT, DATA or ERR1; otherwise go to IDLE.
  - ERR1: hready_out=0, hresp=1 -> ERR2.
  - ERR2: hready_out=1, hresp=1. No RAM access. A new accepted transfer is handled as from IDLE.
- IDLE/BUSY transfers, and transfers with hsel=0, get a zero-wait OKAY and no RAM access.
- Byte enables are little-endian:
  - byte: be = 0001 << addr[1:0]
  - half: be = 0011 << {addr[1],0}
  - word: be = 1111
  - Data is taken from the matching hwdata lanes (no shifting).
- hrdata = 0 in every cycle except a read DATA cycle.
- Address wrap: bits above ADDR_WIDTH are ignored, so 0xB0001010 aliases 0xB0000010 for ADDR_WIDTH=12.
- Back-to-back write then read of the same word: the read returns the new data, because the write commits before the read DATA cycle.
- Latency: an OKAY transfer completes WAIT_STATES+1 cycles after address acceptance. ERROR takes exactly 2 cycles.

Test Plan:
1. Reset held 3 cycles, then released -> hready_out=1, hresp=0, hrdata=0; IDLE transfers -> OKAY with zero wait.
2. WAIT_STATES=2: SW 0xB0000010, hwdata=0xDEADBEEF -> hready_out low 2 cycles, then high. LW 0xB0000010 -> hrdata=0xDEADBEEF in the third data cycle, hresp=0.
3. SB 0xB0000011, hwdata=0x0000AA00 -> LW 0xB0000010 returns 0xDEADAAEF. SH 0xB0000012, hwdata=0x12340000 -> LW returns 0x1234AAEF.
4. SH 0xB0000013 -> cycle 1 hready_out=0, hresp=1; cycle 2 hready_out=1, hresp=1. Subsequent LW 0xB0000010 still reads 0x1234AAEF. Same response for LW 0xB0000012 and for hsize=011.
5. WAIT_STATES=0: pipelined NONSEQ SW 0xB0000020 = 0xCAFEF00D, then LW 0xB0000020 -> hready_out stays 1 throughout, hrdata=0xCAFEF00D in the read data cycle.
6. Reset pulsed during the WAIT of a SW to 0xB0000020 = 0x11111111 -> hready_out=1 immediately. A later LW 0xB0000020 returns the prior 0xCAFEF00D (write discarded).
